// File: rtl/uart_rx_fifo_if.sv
// Host-facing bundle of the UART receive FIFO: write strobe from the receiver,
// FWFT read port, occupancy and sticky error flags.
interface uart_rx_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wr;
    logic [DATA_W-1:0] w_data;
    logic              rd;
    logic              clr_err;
    logic [DATA_W-1:0] r_data;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    // Producer/consumer side (receiver + host).
    modport master (
        output wr, w_data, rd, clr_err,
        input  r_data, empty, full, almost_full, count, overflow, underflow
    );

    // FIFO side.
    modport slave (
        input  wr, w_data, rd, clr_err,
        output r_data, empty, full, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular-register receive FIFO with first-word fall-through read, registered
// occupancy flags and sticky overflow/underflow error reporting.
module uart_rx_fifo #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12
) (
    input  logic            clk,
    input  logic            reset,
    uart_rx_fifo_if.slave   bus
);
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LEVEL);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  we;

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              af_q, af_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              wr_acc;
    logic              rd_acc;

    // A write into a full FIFO still goes through when the head is popped the same cycle.
    assign wr_acc = bus.wr && (!full_q || bus.rd);
    assign rd_acc = bus.rd && !empty_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;

        if (wr_acc) begin
            wptr_d = wptr_q + ADDR_W'(1);
        end
        if (rd_acc) begin
            rptr_d = rptr_q + ADDR_W'(1);
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        // A fresh error event outranks a simultaneous clear.
        if (bus.wr && full_q && !bus.rd) begin
            ovf_d = 1'b1;
        end else if (bus.clr_err) begin
            ovf_d = 1'b0;
        end

        if (bus.rd && empty_q) begin
            udf_d = 1'b1;
        end else if (bus.clr_err) begin
            udf_d = 1'b0;
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);
        af_d    = (count_d >= AF_C);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // One-hot write enable per storage slot; contents survive reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign we[gi] = !reset && wr_acc && (wptr_q == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we[i]) begin
                mem_q[i] <= bus.w_data;
            end
        end
    end

    assign bus.r_data      = mem_q[rptr_q];
    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.count       = count_q;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = udf_q;

endmodule
